button_debounce: RTL and testbench



---
 rtl/button_debounce_if.sv | 28 ++
 rtl/button_debounce.sv | 143 ++++++++++++++
 tb/tb_button_debounce.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/button_debounce_if.sv
// Button pin in, debounced level and event pulses out.
// Master drives the raw pin; slave is the debouncer.
interface button_debounce_if;
  logic BTN;
  logic PRESSED;
  logic PRESS;
  logic RELEASE;
  logic TOGGLE;
  logic LONG;

  modport master (
    output BTN,
    input  PRESSED,
    input  PRESS,
    input  RELEASE,
    input  TOGGLE,
    input  LONG
  );

  modport slave (
    input  BTN,
    output PRESSED,
    output PRESS,
    output RELEASE,
    output TOGGLE,
    output LONG
  );
endinterface

// File: rtl/button_debounce.sv
// Push-button synchroniser, debouncer and press/release/toggle events.
// Define BUTTON_LONGPRESS_EN to build the long-press counter and LONG pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic               CLK50,
  input  logic               RESET_N,
  button_debounce_if.slave   bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE  = DW'(1);
  localparam logic RST_PIN = (ACTIVE_LOW != 0);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  logic [1:0]    r_sync;
  logic          w_s;
  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [DW-1:0] r_cnt;
  logic [DW-1:0] w_cnt_nxt;
  logic          w_press_evt;
  logic          w_release_evt;
  logic          r_pressed;
  logic          r_press;
  logic          r_release;
  logic          r_toggle;

  // Sync flops idle at the released pin level so reset never looks like a press
  always_ff @(posedge CLK50 or negedge RESET_N) begin
    if (!RESET_N) r_sync <= {2{RST_PIN}};
    else          r_sync <= {r_sync[0], bus.BTN};
  end

  assign w_s = RST_PIN ? ~r_sync[1] : r_sync[1];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_s) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = DB_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!w_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + DB_ONE;
        end
      end
      HELD: begin
        if (!w_s) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = DB_ONE;
        end
      end
      default: begin
        if (w_s) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + DB_ONE;
        end
      end
    endcase
  end

  assign w_press_evt   = (r_state == PRESS_WAIT) &&
                         (w_state_nxt == HELD);
  assign w_release_evt = (r_state == RELEASE_WAIT) &&
                         (w_state_nxt == IDLE);

  always_ff @(posedge CLK50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pressed <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_toggle  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pressed <= w_state_nxt[1];
      r_press   <= w_press_evt;
      r_release <= w_release_evt;
      r_toggle  <= r_toggle ^ w_press_evt;
    end
  end

  assign bus.PRESSED = r_pressed;
  assign bus.PRESS   = r_press;
  assign bus.RELEASE = r_release;
  assign bus.TOGGLE  = r_toggle;

`ifdef BUTTON_LONGPRESS_EN
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] LONG_ONE  = LW'(1);

  logic [LW-1:0] r_lcnt;
  logic          r_long;

  // Saturating count fires once per press; release edge masks it
  always_ff @(posedge CLK50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_lcnt <= '0;
      r_long <= 1'b0;
    end else begin
      if (w_press_evt || !r_pressed)
        r_lcnt <= '0;
      else if (r_lcnt != LONG_MAX)
        r_lcnt <= r_lcnt + LONG_ONE;
      r_long <= r_pressed && !w_press_evt &&
                !w_release_evt &&
                (r_lcnt == LONG_LAST);
    end
  end

  assign bus.LONG = r_long;
`else
  assign bus.LONG = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: reset, press, bounce, glitch,
// long press and reset during a held press.
module tb_button_debounce;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  int   cnt_p;
  int   at_p;
  int   cnt_l;
  int   at_l;

  button_debounce_if bif();

  button_debounce #(
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (20),
    .ACTIVE_LOW      (1)
  ) dut (
    .CLK50   (clk),
    .RESET_N (rst_n),
    .bus     (bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bif.BTN = 1'b0;

    // 1: reset with pin pressed
    cyc(3);
    chk("rst_pressed", bif.PRESSED, 0);
    chk("rst_press", bif.PRESS, 0);
    chk("rst_release", bif.RELEASE, 0);
    chk("rst_toggle", bif.TOGGLE, 0);
    chk("rst_long", bif.LONG, 0);
    bif.BTN = 1'b1;
    cyc(1);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("idle_pressed", bif.PRESSED, 0);
      chk("idle_press", bif.PRESS, 0);
    end

    // 2: clean press and release
    bif.BTN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("pw_pressed", bif.PRESSED, 0);
      chk("pw_press", bif.PRESS, 0);
    end
    cyc(1);
    chk("p_pressed", bif.PRESSED, 1);
    chk("p_press", bif.PRESS, 1);
    chk("p_toggle", bif.TOGGLE, 1);
    cyc(1);
    chk("p_press_1cyc", bif.PRESS, 0);
    chk("p_held", bif.PRESSED, 1);
    bif.BTN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("rw_pressed", bif.PRESSED, 1);
      chk("rw_release", bif.RELEASE, 0);
    end
    cyc(1);
    chk("r_pressed", bif.PRESSED, 0);
    chk("r_release", bif.RELEASE, 1);
    chk("r_toggle", bif.TOGGLE, 1);
    chk("r_press", bif.PRESS, 0);
    cyc(1);
    chk("r_release_1cyc", bif.RELEASE, 0);

    // 3: bouncing press never accepted
    bif.BTN = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) bif.BTN = 1'b1;
      if (i == 4) bif.BTN = 1'b0;
      if (i == 6) bif.BTN = 1'b1;
      cyc(1);
      chk("bnc_pressed", bif.PRESSED, 0);
      chk("bnc_press", bif.PRESS, 0);
    end
    bif.BTN = 1'b0;
    cnt_p = 0;
    at_p  = -1;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (bif.PRESS === 1'b1) begin
        cnt_p++;
        at_p = i;
      end
    end
    chk("bnc_press_count", cnt_p, 1);
    chk("bnc_press_at", at_p, 6);
    chk("bnc_held", bif.PRESSED, 1);
    chk("bnc_toggle", bif.TOGGLE, 0);

    // 4: release glitch ignored
    bif.BTN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) bif.BTN = 1'b0;
      cyc(1);
      chk("gl_pressed", bif.PRESSED, 1);
      chk("gl_release", bif.RELEASE, 0);
      chk("gl_long", bif.LONG, 0);
    end
    bif.BTN = 1'b1;
    cyc(6);
    chk("gl_rel_pulse", bif.RELEASE, 1);
    cyc(2);

    // 5: long press
    bif.BTN = 1'b0;
    cyc(6);
    chk("lp_press", bif.PRESS, 1);
    chk("lp_toggle", bif.TOGGLE, 1);
    cnt_l = 0;
    at_l  = -1;
    cnt_p = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      if (bif.LONG === 1'b1) begin
        cnt_l++;
        at_l = i;
      end
      if (bif.PRESS === 1'b1) cnt_p++;
    end
`ifdef BUTTON_LONGPRESS_EN
    chk("lp_long_count", cnt_l, 1);
    chk("lp_long_at", at_l, 20);
`else
    chk("lp_long_count", cnt_l, 0);
    chk("lp_long_at", at_l, -1);
`endif
    chk("lp_no_repress", cnt_p, 0);
    chk("lp_held", bif.PRESSED, 1);
    bif.BTN = 1'b1;
    cyc(6);
    chk("lp_release", bif.RELEASE, 1);
    chk("lp_rel_long", bif.LONG, 0);
    cyc(2);

    // 6: reset while held
    bif.BTN = 1'b0;
    cyc(6);
    chk("mr_press", bif.PRESS, 1);
    chk("mr_toggle", bif.TOGGLE, 0);
    cyc(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_pressed0", bif.PRESSED, 0);
    chk("mr_toggle0", bif.TOGGLE, 0);
    chk("mr_press0", bif.PRESS, 0);
    cyc(2);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("mr_wait_press", bif.PRESS, 0);
      chk("mr_wait_rel", bif.RELEASE, 0);
      chk("mr_wait_held", bif.PRESSED, 0);
    end
    cyc(1);
    chk("mr_repress", bif.PRESS, 1);
    chk("mr_reheld", bif.PRESSED, 1);
    chk("mr_retoggle", bif.TOGGLE, 1);
    chk("mr_norel", bif.RELEASE, 0);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
